am_query_scheduler: RTL and testbench
=====================================

# am_query_scheduler

Round-robin scheduler that shares one non-pipelined associative memory (AM) classifier between `NUM_REQ` query sources, for example several fusion front-ends. It holds one query at a time. It latches the winning requester's three modality hypervectors, issues them to the AM over valid/ready, and collects the A/V label and distance pair. It then returns that pair to the originating requester, tagged with the AM service latency. It sits between the spatial/temporal encoders and the AM instance.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `HV_DIMENSION`, 2000: hypervector width per modality.
- `LABEL_WIDTH`, 1: AM label width.
- `DISTANCE_WIDTH`, 11: AM distance width.
- `LAT_WIDTH`, 8: width of the latency counter.

Ports:
- `Clk_CI` in 1: single clock, rising edge.
- `Reset_RBI` in 1: asynchronous, active-low reset.
- `ValidIn_SI` in `NUM_REQ`: per-requester query valid.
- `ReadyOut_SO` out `NUM_REQ`: per-requester query accepted.
- `HvMod1_DI`, `HvMod2_DI`, `HvMod3_DI` in `NUM_REQ*HV_DIMENSION` each: requester i uses slice `[i*HV_DIMENSION +: HV_DIMENSION]`.
- `ValidOut_SO` out `NUM_REQ`: result valid for requester i.
- `ReadyIn_SI` in `NUM_REQ`: requester i accepts its result.
- `LabelOut_A_DO`, `LabelOut_V_DO` out `LABEL_WIDTH`: result labels. These are broadcast and are only meaningful where `ValidOut_SO` is set.
- `DistanceOut_A_DO`, `DistanceOut_V_DO` out `DISTANCE_WIDTH`: result distances.
- `LatencyOut_DO` out `LAT_WIDTH`: AM service cycles for this result.
- `AmValidOut_SO` out 1, `AmReadyIn_SI` in 1: query channel to the AM.
- `AmHvMod1_DO`, `AmHvMod2_DO`, `AmHvMod3_DO` out `HV_DIMENSION`: latched query to the AM.
- `AmValidIn_SI` in 1, `AmReadyOut_SO` out 1: result channel from the AM.
- `AmLabel_A_DI`, `AmLabel_V_DI`, `AmDistance_A_DI`, `AmDistance_V_DI` in: AM results.

## Operation
State machine `IDLE → ISSUE → WAIT_RESULT → DELIVER → IDLE`.
- **IDLE**
  - Grant goes to the lowest index ≥ `RrPtr` (wrapping) with `ValidIn_SI` set.
  - `ReadyOut_SO[grant]` is driven high combinationally in the same cycle.
  - On that cycle, latch the grant index and the three slices; go to ISSUE.
  - No valid input: stay in IDLE.
- **ISSUE**
  - `AmValidOut_SO=1`; `AmHvMod*_DO` comes from the query registers and is stable.
  - `AmValidOut_SO` is held until `AmReadyIn_SI`; on that handshake go to WAIT_RESULT.
- **WAIT_RESULT**
  - `AmReadyOut_SO=1`.
  - On `AmValidIn_SI`, latch labels, distances and the latency count; go to DELIVER.
- **DELIVER**
  - `ValidOut_SO[grant]=1`; outputs are held until `ReadyIn_SI[grant]`.
  - On that handshake, `RrPtr ← (grant+1) mod NUM_REQ`; go to IDLE.
  - `ReadyIn_SI` of other requesters is ignored.
- **Latency counter**
  - Cleared on entry to ISSUE.
  - Increments every cycle in ISSUE and WAIT_RESULT.
  - Saturates at `2^LAT_WIDTH-1`.
  - The latched value is the count at the `AmValidIn_SI` cycle, counting that cycle.
- **Rules and boundary conditions**
  - Only one query is outstanding. `ReadyOut_SO` is all-zero outside IDLE.
  - Requesters must hold `ValidIn_SI` and data until accepted. Dropping valid before the grant just removes that requester from arbitration.
  - A requester that is re-asserting valid while its result is in DELIVER is not served until the next IDLE.
  - `AmValidIn_SI` outside WAIT_RESULT is ignored (`AmReadyOut_SO=0`).
  - `RrPtr` wraps from `NUM_REQ-1` to 0.

## Timing
- **Reset values:** all `*_SO` = 0, all data outputs = 0, `RrPtr=0`, state IDLE, query registers 0.
- **Reset mid-operation:** any assertion of `Reset_RBI` immediately returns to reset values. An in-flight AM query is abandoned, and the AM must be reset alongside.
- Accept at cycle 0 gives `AmValidOut_SO` at cycle 1.
- AM result at cycle t gives `ValidOut_SO` at t+1.
- Scheduler overhead is 2 cycles per query, plus the result-handshake wait.
- Back-to-back queries: the next accept is possible on the cycle after the DELIVER handshake.

## Structure
- **Shared package `am_ctrl_pkg`:**
  - state enum `{IDLE, ISSUE, WAIT_RESULT, DELIVER}` (2 bits);
  - `clog2` function for the grant and pointer width (minimum 1).
- **Sub-module `rr_arbiter`:**
  - combinational round-robin pick from `req[NUM_REQ-1:0]` and `ptr`;
  - outputs a one-hot grant, the grant index and `any`.

## Test plan
- **Single requester:** requester 1 valid with HV slices, AM ready immediately, AM result (A=1, dA=5, V=0, dV=9) after 10 cycles.
  - `ReadyOut_SO=2'b10` at cycle 0, `AmValidOut_SO` at 1.
  - `ValidOut_SO=2'b10` with those values and `LatencyOut_DO=11`.
- **Contention:** both requesters valid from reset.
  - Requester 0 is served first, then 1.
  - With both permanently valid, grants alternate 0,1,0,1.
- **Back-pressure:**
  - `AmReadyIn_SI` low for 4 cycles: `AmValidOut_SO` and the query data are held stable for 5 cycles.
  - `ReadyIn_SI` low for 3 cycles: `ValidOut_SO` and the result are held, and no new `ReadyOut_SO` is given.
- **Stray AM valid and saturation:**
  - `AmValidIn_SI` pulsed in IDLE: no state change, no output.
  - `LAT_WIDTH=4` with a 20-cycle AM: `LatencyOut_DO=15`.
- **Async reset in WAIT_RESULT:** all outputs are 0 immediately, without waiting for a clock edge. After release, requester 0 has priority.

Source files
------------

// File: rtl/am_query_scheduler_pkg.sv
// Shared types for the AM query scheduler: controller state encoding and
// the index-width helper used for grant and round-robin pointer registers.
package am_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        DELIVER     = 2'd3
    } am_state_e;

    // Never narrower than one bit, so a two-requester build still has a pointer.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/am_query_scheduler_if.sv
// Requester and AM handshake bundle for the query scheduler; the scheduler
// uses the master view, the surrounding requesters/AM use the slave view.
interface am_query_scheduler_if #(
    parameter int NUM_REQ        = 2,
    parameter int HV_DIMENSION   = 2000,
    parameter int LABEL_WIDTH    = 1,
    parameter int DISTANCE_WIDTH = 11,
    parameter int LAT_WIDTH      = 8
);
    logic [NUM_REQ-1:0]              ValidIn_SI;
    logic [NUM_REQ-1:0]              ReadyOut_SO;
    logic [NUM_REQ*HV_DIMENSION-1:0] HvMod1_DI;
    logic [NUM_REQ*HV_DIMENSION-1:0] HvMod2_DI;
    logic [NUM_REQ*HV_DIMENSION-1:0] HvMod3_DI;
    logic [NUM_REQ-1:0]              ValidOut_SO;
    logic [NUM_REQ-1:0]              ReadyIn_SI;
    logic [LABEL_WIDTH-1:0]          LabelOut_A_DO;
    logic [LABEL_WIDTH-1:0]          LabelOut_V_DO;
    logic [DISTANCE_WIDTH-1:0]       DistanceOut_A_DO;
    logic [DISTANCE_WIDTH-1:0]       DistanceOut_V_DO;
    logic [LAT_WIDTH-1:0]            LatencyOut_DO;
    logic                            AmValidOut_SO;
    logic                            AmReadyIn_SI;
    logic [HV_DIMENSION-1:0]         AmHvMod1_DO;
    logic [HV_DIMENSION-1:0]         AmHvMod2_DO;
    logic [HV_DIMENSION-1:0]         AmHvMod3_DO;
    logic                            AmValidIn_SI;
    logic                            AmReadyOut_SO;
    logic [LABEL_WIDTH-1:0]          AmLabel_A_DI;
    logic [LABEL_WIDTH-1:0]          AmLabel_V_DI;
    logic [DISTANCE_WIDTH-1:0]       AmDistance_A_DI;
    logic [DISTANCE_WIDTH-1:0]       AmDistance_V_DI;

    modport master (
        input  ValidIn_SI, HvMod1_DI, HvMod2_DI, HvMod3_DI, ReadyIn_SI,
        input  AmReadyIn_SI, AmValidIn_SI,
        input  AmLabel_A_DI, AmLabel_V_DI, AmDistance_A_DI, AmDistance_V_DI,
        output ReadyOut_SO, ValidOut_SO,
        output LabelOut_A_DO, LabelOut_V_DO, DistanceOut_A_DO, DistanceOut_V_DO,
        output LatencyOut_DO,
        output AmValidOut_SO, AmHvMod1_DO, AmHvMod2_DO, AmHvMod3_DO, AmReadyOut_SO
    );

    modport slave (
        output ValidIn_SI, HvMod1_DI, HvMod2_DI, HvMod3_DI, ReadyIn_SI,
        output AmReadyIn_SI, AmValidIn_SI,
        output AmLabel_A_DI, AmLabel_V_DI, AmDistance_A_DI, AmDistance_V_DI,
        input  ReadyOut_SO, ValidOut_SO,
        input  LabelOut_A_DO, LabelOut_V_DO, DistanceOut_A_DO, DistanceOut_V_DO,
        input  LatencyOut_DO,
        input  AmValidOut_SO, AmHvMod1_DO, AmHvMod2_DO, AmHvMod3_DO, AmReadyOut_SO
    );
endinterface

// File: rtl/am_query_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import am_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/am_query_scheduler.sv
// Shares one non-pipelined AM classifier between NUM_REQ query sources,
// one query in flight at a time, results tagged with AM service latency.
//
// state       | meaning
// IDLE        | arbitrate, accept winner and latch its hypervectors
// ISSUE       | present latched query to the AM until it is taken
// WAIT_RESULT | accept the AM result, latch labels/distances/latency
// DELIVER     | hold result for the granted requester until it is taken
module am_query_scheduler
    import am_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int HV_DIMENSION   = 2000,
    parameter int LABEL_WIDTH    = 1,
    parameter int DISTANCE_WIDTH = 11,
    parameter int LAT_WIDTH      = 8
) (
    input logic                  Clk_CI,
    input logic                  Reset_RBI,
    am_query_scheduler_if.master bus
);

    localparam int IDX_W = clog2(NUM_REQ);

    am_state_e                 state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [HV_DIMENSION-1:0]   hv1_q, hv1_d, hv2_q, hv2_d, hv3_q, hv3_d;
    logic [LAT_WIDTH-1:0]      lat_cnt_q, lat_cnt_d, lat_out_q, lat_out_d;
    logic [LABEL_WIDTH-1:0]    label_a_q, label_a_d, label_v_q, label_v_d;
    logic [DISTANCE_WIDTH-1:0] dist_a_q, dist_a_d, dist_v_q, dist_v_d;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_any;
    logic [LAT_WIDTH-1:0]      lat_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.ValidIn_SI),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (arb_any)                    state_d = ISSUE;
            ISSUE:       if (bus.AmReadyIn_SI)           state_d = WAIT_RESULT;
            WAIT_RESULT: if (bus.AmValidIn_SI)           state_d = DELIVER;
            DELIVER:     if (bus.ReadyIn_SI[grant_q])    state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // Reset also gates the combinational accept so nothing handshakes while held.
    always_comb begin
        bus.ReadyOut_SO   = (state_q == IDLE && Reset_RBI) ? arb_gnt : '0;
        bus.AmValidOut_SO = (state_q == ISSUE);
        bus.AmReadyOut_SO = (state_q == WAIT_RESULT);
        bus.ValidOut_SO   = (state_q == DELIVER) ? (NUM_REQ'(1) << grant_q) : '0;
    end

    assign lat_inc = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_WIDTH'(1);

    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hv1_d     = hv1_q;
        hv2_d     = hv2_q;
        hv3_d     = hv3_q;
        lat_cnt_d = lat_cnt_q;
        lat_out_d = lat_out_q;
        label_a_d = label_a_q;
        label_v_d = label_v_q;
        dist_a_d  = dist_a_q;
        dist_v_d  = dist_v_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d   = arb_idx;
                    hv1_d     = bus.HvMod1_DI[arb_idx*HV_DIMENSION +: HV_DIMENSION];
                    hv2_d     = bus.HvMod2_DI[arb_idx*HV_DIMENSION +: HV_DIMENSION];
                    hv3_d     = bus.HvMod3_DI[arb_idx*HV_DIMENSION +: HV_DIMENSION];
                    lat_cnt_d = '0;
                end
            end
            ISSUE: lat_cnt_d = lat_inc;
            WAIT_RESULT: begin
                lat_cnt_d = lat_inc;
                if (bus.AmValidIn_SI) begin
                    lat_out_d = lat_inc;
                    label_a_d = bus.AmLabel_A_DI;
                    label_v_d = bus.AmLabel_V_DI;
                    dist_a_d  = bus.AmDistance_A_DI;
                    dist_v_d  = bus.AmDistance_V_DI;
                end
            end
            DELIVER: begin
                if (bus.ReadyIn_SI[grant_q])
                    ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            grant_q   <= '0;
            ptr_q     <= '0;
            hv1_q     <= '0;
            hv2_q     <= '0;
            hv3_q     <= '0;
            lat_cnt_q <= '0;
            lat_out_q <= '0;
            label_a_q <= '0;
            label_v_q <= '0;
            dist_a_q  <= '0;
            dist_v_q  <= '0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hv1_q     <= hv1_d;
            hv2_q     <= hv2_d;
            hv3_q     <= hv3_d;
            lat_cnt_q <= lat_cnt_d;
            lat_out_q <= lat_out_d;
            label_a_q <= label_a_d;
            label_v_q <= label_v_d;
            dist_a_q  <= dist_a_d;
            dist_v_q  <= dist_v_d;
        end
    end

    assign bus.AmHvMod1_DO      = hv1_q;
    assign bus.AmHvMod2_DO      = hv2_q;
    assign bus.AmHvMod3_DO      = hv3_q;
    assign bus.LabelOut_A_DO    = label_a_q;
    assign bus.LabelOut_V_DO    = label_v_q;
    assign bus.DistanceOut_A_DO = dist_a_q;
    assign bus.DistanceOut_V_DO = dist_v_q;
    assign bus.LatencyOut_DO    = lat_out_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Randomized bench for am_query_scheduler: requester/AM models drive the DUT,
// a scoreboard queue holds expected results and a monitor checks deliveries.
module tb_am_query_scheduler;

    localparam int N       = 2;
    localparam int HV      = 16;
    localparam int LW      = 1;
    localparam int DW      = 11;
    localparam int TW      = 4;
    localparam int LAT_MAX = (1 << TW) - 1;

    typedef struct packed {
        logic          la;
        logic          lv;
        logic [DW-1:0] da;
        logic [DW-1:0] dv;
    } res_t;

    localparam res_t FIXED_RES = '{la: 1'b1, lv: 1'b0, da: 11'd5, dv: 11'd9};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    am_query_scheduler_if #(.NUM_REQ(N), .HV_DIMENSION(HV), .LABEL_WIDTH(LW),
                            .DISTANCE_WIDTH(DW), .LAT_WIDTH(TW)) bus ();

    am_query_scheduler #(.NUM_REQ(N), .HV_DIMENSION(HV), .LABEL_WIDTH(LW),
                         .DISTANCE_WIDTH(DW), .LAT_WIDTH(TW)) u_dut (
        .Clk_CI    (clk),
        .Reset_RBI (rst_n),
        .bus       (bus.master)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    int   lat_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t am_fn(input logic [HV-1:0] h1, input logic [HV-1:0] h2,
                                   input logic [HV-1:0] h3);
        res_t r;
        r.la = (^h1) ^ h3[0];
        r.lv = ^h2;
        r.da = DW'($countones(h1 ^ h3));
        r.dv = DW'($countones(h2)) + DW'(h3[3:0]);
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Environment knobs; negative delay means randomize per transaction.
    bit           env_en    = 0;
    logic [N-1:0] req_mask  = '0;
    int           req_prob  = 0;
    int           rdy_lat   = 0;
    int           res_gap   = 1;
    int           rdyin_lat = 0;
    bit           am_fixed  = 0;

    bit            pend[N];
    logic [HV-1:0] q1[N], q2[N], q3[N];
    logic [N-1:0]  drop = '0;
    bit            busy = 0, acc_prev = 0, res_prev = 0, dlv = 0;
    int            ptr_m = 0, gnt_m = 0, rin_left = 0, deliveries = 0;
    int            am_st = 0, am_cnt = 0, rdy_w = 0, target = 0;
    logic [3*HV-1:0] am_cap;
    res_t          am_res;

    // Requester + AM behavioural environment: drive at negedge, observe 1 later.
    initial begin : env
        bit   acc_now, res_now;
        int   pick;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) pend[i] = 0;
        forever begin
            @(negedge clk);
            if (env_en) begin
                for (int i = 0; i < N; i++) begin
                    if (drop[i]) begin
                        bus.ValidIn_SI[i] = 1'b0;
                        drop[i] = 1'b0;
                    end
                    if (!pend[i] && req_mask[i] && int'($urandom_range(99)) < req_prob) begin
                        pend[i] = 1;
                        q1[i] = HV'($urandom);
                        q2[i] = HV'($urandom);
                        q3[i] = HV'($urandom);
                        bus.HvMod1_DI[i*HV +: HV] = q1[i];
                        bus.HvMod2_DI[i*HV +: HV] = q2[i];
                        bus.HvMod3_DI[i*HV +: HV] = q3[i];
                        bus.ValidIn_SI[i] = 1'b1;
                    end
                end
                bus.ReadyIn_SI = N'($urandom);
                if (res_prev) begin
                    dlv = 1;
                    rin_left = (rdyin_lat < 0) ? int'($urandom_range(3)) : rdyin_lat;
                end
                if (dlv) bus.ReadyIn_SI[gnt_m] = (rin_left == 0);

                bus.AmReadyIn_SI    = 1'b0;
                bus.AmValidIn_SI    = 1'b0;
                bus.AmLabel_A_DI    = LW'($urandom);
                bus.AmLabel_V_DI    = LW'($urandom);
                bus.AmDistance_A_DI = DW'($urandom);
                bus.AmDistance_V_DI = DW'($urandom);
                res_now = 0;
                if (acc_prev) begin
                    am_st  = 1;
                    am_cnt = 0;
                    rdy_w  = (rdy_lat < 0) ? int'($urandom_range(5)) : rdy_lat;
                end
                if (am_st != 0) am_cnt++;
                if (am_st == 1 && am_cnt > rdy_w) bus.AmReadyIn_SI = 1'b1;
                if (am_st == 2 && am_cnt == target) begin
                    bus.AmValidIn_SI    = 1'b1;
                    bus.AmLabel_A_DI    = am_res.la;
                    bus.AmLabel_V_DI    = am_res.lv;
                    bus.AmDistance_A_DI = am_res.da;
                    bus.AmDistance_V_DI = am_res.dv;
                    res_now = 1;
                end

                #1;
                pick    = busy ? -1 : rr_pick(bus.ValidIn_SI, ptr_m);
                exp_rdy = (pick >= 0) ? (N'(1) << pick) : '0;
                check("ready_out", bus.ReadyOut_SO, exp_rdy);
                acc_now = 0;
                if (pick >= 0) begin
                    busy = 1;
                    gnt_m = pick;
                    pend[pick] = 0;
                    drop[pick] = 1'b1;
                    exp_q.push_back(am_fixed ? FIXED_RES : am_fn(q1[pick], q2[pick], q3[pick]));
                    acc_now = 1;
                end

                check("am_valid_out", bus.AmValidOut_SO, am_st == 1);
                check("am_ready_out", bus.AmReadyOut_SO, am_st == 2);
                if (am_st == 1) begin
                    if (am_cnt == 1)
                        am_cap = {bus.AmHvMod1_DO, bus.AmHvMod2_DO, bus.AmHvMod3_DO};
                    else
                        check("am_hv_hold", {bus.AmHvMod1_DO, bus.AmHvMod2_DO, bus.AmHvMod3_DO}, am_cap);
                    if (bus.AmReadyIn_SI) begin
                        am_res = am_fixed ? FIXED_RES
                                          : am_fn(bus.AmHvMod1_DO, bus.AmHvMod2_DO, bus.AmHvMod3_DO);
                        am_st  = 2;
                        target = am_cnt + ((res_gap < 0) ? int'($urandom_range(12, 1)) : res_gap);
                    end
                end else if (am_st == 2 && res_now) begin
                    lat_q.push_back((am_cnt > LAT_MAX) ? LAT_MAX : am_cnt);
                    am_st = 0;
                end

                check("valid_out", bus.ValidOut_SO, dlv ? (N'(1) << gnt_m) : '0);
                if (dlv) begin
                    if (bus.ReadyIn_SI[gnt_m]) begin
                        dlv = 0;
                        busy = 0;
                        ptr_m = (gnt_m + 1) % N;
                        deliveries++;
                    end else begin
                        rin_left--;
                    end
                end
                acc_prev = acc_now;
                res_prev = res_now;
            end
        end
    end

    // Scoreboard monitor: compares every presented result, pops on handshake.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.ValidOut_SO != '0) begin
                if (exp_q.size() == 0 || lat_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL result_unexpected: ValidOut=%b with no queued expectation at %0t",
                             bus.ValidOut_SO, $time);
                end else begin
                    e = exp_q[0];
                    check("label_a", bus.LabelOut_A_DO, e.la);
                    check("label_v", bus.LabelOut_V_DO, e.lv);
                    check("dist_a", bus.DistanceOut_A_DO, e.da);
                    check("dist_v", bus.DistanceOut_V_DO, e.dv);
                    check("latency", bus.LatencyOut_DO, lat_q[0]);
                    if ((bus.ValidOut_SO & bus.ReadyIn_SI) != '0) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_deliv(input int n);
        int tgt, budget;
        tgt = deliveries + n;
        budget = 3000;
        while (deliveries < tgt && budget > 0) begin
            step();
            budget--;
        end
        if (deliveries < tgt) begin
            n_tests++;
            n_fail++;
            $display("FAIL deliver_timeout: got %0d deliveries expected %0d", deliveries, tgt);
        end
    endtask

    task automatic quiesce();
        int budget;
        req_mask = '0;
        budget = 3000;
        while ((busy || pend[0] || pend[1]) && budget > 0) begin
            step();
            budget--;
        end
        if (busy || pend[0] || pend[1]) begin
            n_tests++;
            n_fail++;
            $display("FAIL quiesce_timeout: got busy=%0d expected 0", busy);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.ValidIn_SI      = '0;
        bus.HvMod1_DI       = '0;
        bus.HvMod2_DI       = '0;
        bus.HvMod3_DI       = '0;
        bus.ReadyIn_SI      = '0;
        bus.AmReadyIn_SI    = 1'b0;
        bus.AmValidIn_SI    = 1'b0;
        bus.AmLabel_A_DI    = '0;
        bus.AmLabel_V_DI    = '0;
        bus.AmDistance_A_DI = '0;
        bus.AmDistance_V_DI = '0;

        // Reset state, with valid requests present to show accept is gated.
        repeat (2) step();
        bus.ValidIn_SI = 2'b11;
        #1;
        check("rst_ready_out", bus.ReadyOut_SO, 2'b00);
        check("rst_valid_out", bus.ValidOut_SO, 2'b00);
        check("rst_am_valid", bus.AmValidOut_SO, 1'b0);
        check("rst_am_ready", bus.AmReadyOut_SO, 1'b0);
        check("rst_am_hv", {bus.AmHvMod1_DO, bus.AmHvMod2_DO, bus.AmHvMod3_DO}, '0);
        check("rst_latency", bus.LatencyOut_DO, '0);
        check("rst_dist", {bus.DistanceOut_A_DO, bus.DistanceOut_V_DO}, '0);
        bus.ValidIn_SI = 2'b00;
        step();
        rst_n = 1'b1;
        step();

        // Single requester, fixed AM result after ten cycles.
        am_fixed = 1; req_mask = 2'b10; req_prob = 100;
        rdy_lat = 0; res_gap = 10; rdyin_lat = 0;
        env_en = 1;
        wait_deliv(2);
        quiesce();

        // Contention: both permanently valid, grants must alternate.
        am_fixed = 0; req_mask = 2'b11; req_prob = 100;
        rdy_lat = 0; res_gap = -1; rdyin_lat = 0;
        wait_deliv(6);

        // Back-pressure on both AM accept and result accept.
        rdy_lat = 4; res_gap = 3; rdyin_lat = 3;
        wait_deliv(3);

        // Slow AM: latency saturates.
        rdy_lat = 0; res_gap = 20; rdyin_lat = 0;
        wait_deliv(2);

        // Random traffic.
        rdy_lat = -1; res_gap = -1; rdyin_lat = -1; req_prob = 40;
        wait_deliv(40);
        quiesce();
        env_en = 0;
        step();
        bus.ValidIn_SI   = '0;
        bus.ReadyIn_SI   = '0;
        bus.AmReadyIn_SI = 1'b0;
        bus.AmValidIn_SI = 1'b0;

        // Stray AM result while idle.
        @(negedge clk);
        bus.AmValidIn_SI = 1'b1;
        bus.AmLabel_A_DI = 1'b1;
        bus.AmDistance_A_DI = 11'd77;
        #1;
        check("stray_am_ready", bus.AmReadyOut_SO, 1'b0);
        check("stray_valid_out", bus.ValidOut_SO, 2'b00);
        @(negedge clk);
        bus.AmValidIn_SI = 1'b0;
        #1;
        check("stray_valid_out_after", bus.ValidOut_SO, 2'b00);
        check("stray_am_valid_after", bus.AmValidOut_SO, 1'b0);

        // Drive into WAIT_RESULT, then assert reset mid-cycle.
        @(negedge clk);
        bus.HvMod1_DI[HV +: HV] = 16'hA5C3;
        bus.ValidIn_SI = 2'b10;
        #1;
        check("manual_accept", bus.ReadyOut_SO, 2'b10);
        @(negedge clk);
        bus.ValidIn_SI   = 2'b11;
        bus.AmReadyIn_SI = 1'b1;
        #1;
        check("manual_issue", bus.AmValidOut_SO, 1'b1);
        check("manual_no_accept", bus.ReadyOut_SO, 2'b00);
        check("manual_query", bus.AmHvMod1_DO, 16'hA5C3);
        @(negedge clk);
        bus.AmReadyIn_SI = 1'b0;
        #1;
        check("manual_wait", bus.AmReadyOut_SO, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready_out", bus.ReadyOut_SO, 2'b00);
        check("arst_am_ready", bus.AmReadyOut_SO, 1'b0);
        check("arst_am_valid", bus.AmValidOut_SO, 1'b0);
        check("arst_valid_out", bus.ValidOut_SO, 2'b00);
        check("arst_am_hv", bus.AmHvMod1_DO, '0);
        check("arst_latency", bus.LatencyOut_DO, '0);
        check("arst_labels", {bus.LabelOut_A_DO, bus.LabelOut_V_DO}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_priority", bus.ReadyOut_SO, 2'b01);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
